modbus_tx_framer: RTL and testbench
===================================

# modbus_tx_framer

Transmit-side Modbus RTU frame builder: latches a BYTES-long response payload and computes the Modbus CRC-16 over it. It then streams payload plus CRC (low byte first) byte-by-byte to the UART transmitter over a valid/ready handshake. It sits between the slave's response generator and the UART TX, and is the outbound counterpart of the receive-side CRC checker.

## Interface
- BYTES, 6, payload length in bytes (excluding CRC); 1..255
- GAP_CYCLES, 3500, post-frame idle cycles (used only with MODBUS_TX_GAP_EN); ≥1
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- data_in  input  8*BYTES  payload; data_in[7:0] is the first byte on the wire
- tx_start  input  1  request to send one frame; sampled only in IDLE
- busy  output  1  high from the cycle after tx_start is accepted until frame_done
- tx_byte  output  8  byte to UART TX
- tx_byte_valid  output  1  tx_byte valid
- tx_byte_ready  input  1  UART TX can accept a byte
- crc_out  output  16  CRC of last frame, {hi,lo}
- frame_done  output  1  one-cycle pulse; frame fully handed off

## Operation
- CRC: init 16'hFFFF, reflected poly 16'hA001, LSB-first. Per byte: crc[7:0] ^= byte, then 8 steps of crc = crc[0] ? (crc>>1)^16'hA001 : crc>>1.
- FSM states: IDLE, LOAD, XOR, SHIFT, SEND, GAP (macro only), DONE.
- IDLE: tx_start=1 → LOAD. tx_start in any other state is ignored (not queued).
- LOAD: data_buf←data_in, crc←16'hFFFF, byte counter←0 → XOR.
- XOR: crc[7:0]^=data_buf[7:0], bit counter←0 → SHIFT.
- SHIFT: one combined shift/xor step per cycle. After the 8th step, data_buf>>=8 and the byte counter increments. Next state is XOR if more bytes remain, else SEND, loading crc_out and reloading data_buf from the LOAD copy.
- SEND: sends BYTES+2 bytes: payload in order, then crc[7:0], then crc[15:8].
  - tx_byte_valid is held high and tx_byte held stable until a cycle with tx_byte_valid & tx_byte_ready.
  - The next byte is presented on the following cycle, so back-to-back transfers are allowed.
  - After the last accept the FSM goes to DONE, or to GAP with the macro.
- DONE: frame_done=1 and busy=0 for one cycle → IDLE.
- Reset values: busy 0, tx_byte 8'h00, tx_byte_valid 0, crc_out 16'h0000, frame_done 0, state IDLE.
- Reset mid-frame: all outputs return to reset values immediately. No partial frame resumes, and no frame_done is issued.
- data_in changes after LOAD have no effect on the frame in flight.
- tx_byte_ready high outside SEND is ignored.

## Timing
- tx_start sampled at edge N → LOAD. The CRC phase occupies edges N+1 … N+1+9*BYTES.
- tx_byte_valid is first high after edge N+1+9*BYTES (edge N+55 for BYTES=6).
- With ready tied high, the frame takes BYTES+2 cycles in SEND. frame_done pulses on the cycle after the last accept; with the macro, it pulses GAP_CYCLES cycles later.
- crc_out is valid from SEND entry and holds until the next frame's SEND entry.
- busy rises after edge N and falls with frame_done.

## Configuration
- MODBUS_TX_GAP_EN defined: after the final CRC byte is accepted, the FSM stays in GAP for GAP_CYCLES cycles (busy=1, tx_byte_valid=0) before DONE. This enforces the 3.5-character inter-frame silence.
- Undefined: GAP state and counter are absent; DONE follows the last accept directly and GAP_CYCLES is unused.

## Structure
- Package modbus_pkg: CRC_INIT=16'hFFFF, CRC_POLY=16'hA001, the FSM state typedef, and a byte-counter width function (clog2(BYTES+2)).
- Sub-module modbus_crc16_byte: sequential byte CRC engine (start, byte in, crc in/out, done after 9 cycles). It is reusable by the receive path.

## Test plan
- Payload 01 03 00 00 00 0A (data_in=48'h0A000000_0301), ready tied high → bytes 01 03 00 00 00 0A C5 CD, crc_out=16'hCDC5, one frame_done pulse.
- Payload 01 06 00 01 00 03 with ready toggling randomly → bytes 01 06 00 01 00 03 98 0B. tx_byte stays stable while valid & !ready, and no byte is duplicated or dropped.
- tx_start pulsed while busy, and data_in changed mid-frame → single frame of the originally latched payload; the second request is ignored.
- rst_n_in asserted during the 4th SEND byte → valid, busy and crc_out are 0 immediately. A following tx_start sends a complete, correct frame.
- Measure latency (BYTES=6): tx_start at edge N → first valid after edge N+55, and frame_done one cycle after the 8th accept.
- MODBUS_TX_GAP_EN with GAP_CYCLES=10 → frame_done exactly 10 cycles after the last accept, with valid low throughout the gap.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU transmit path and the reusable CRC engine.
//   CRC_INIT / CRC_POLY : Modbus CRC-16 seed and reflected polynomial
//   tx_state_t          : framer FSM states (GAP only reachable with MODBUS_TX_GAP_EN)
//   cnt_width()         : counter width able to index BYTES payload bytes plus two CRC bytes
//   crc_shift()         : one LSB-first shift/xor step of the reflected CRC
package modbus_pkg;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    XOR   = 3'd2,
    SHIFT = 3'd3,
    SEND  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } tx_state_t;

  function automatic int unsigned cnt_width(input int unsigned bytes);
    return $clog2(bytes + 2);
  endfunction

  function automatic logic [15:0] crc_shift(input logic [15:0] crc);
    return crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// Sequential Modbus CRC-16 byte engine: one byte folded in over 9 cycles
// (1 xor cycle + 8 shift cycles). Shared by the transmit framer and receive checker.
//   clk_in, rst_n_in : clock, async active-low reset
//   start            : fold byte_in into crc_in this cycle, then run 8 shift steps
//   byte_in, crc_in  : byte to absorb and running CRC seed (sampled on start)
//   crc_out          : registered running CRC
//   crc_next_c       : value crc_out takes at the next edge
//   done_c           : high during the 9th cycle (final shift step)
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out,
  output logic [15:0] crc_next_c,
  output logic        done_c
);

  logic [2:0] bit_cnt;
  logic       active;

  // Next CRC: seed xor on start, one reflected step while active, else hold.
  always_comb begin
    crc_next_c = crc_out;
    if (start) begin
      crc_next_c = crc_in ^ {8'h00, byte_in};
    end else if (active) begin
      crc_next_c = crc_shift(crc_out);
    end
  end

  assign done_c = active && (bit_cnt == 3'd7);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc_out <= 16'h0000;
      bit_cnt <= 3'd0;
      active  <= 1'b0;
    end else begin
      crc_out <= crc_next_c;
      if (start) begin
        bit_cnt <= 3'd0;
        active  <= 1'b1;
      end else if (active) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/modbus_tx_framer.sv
// Modbus RTU transmit framer: latches a BYTES-long payload, computes its CRC-16,
// then streams payload followed by CRC low/high bytes over a valid/ready handshake.
// Optional feature macro: MODBUS_TX_GAP_EN adds a GAP_CYCLES post-frame silence.
//   clk_in, rst_n_in : clock, async active-low reset
//   data_in          : payload, data_in[7:0] is the first byte on the wire
//   tx_start         : frame request, honoured only in IDLE
//   busy             : frame in progress (cycle after accept until frame_done)
//   tx_byte, tx_byte_valid, tx_byte_ready : byte stream to the UART transmitter
//   crc_out          : CRC of the last frame {hi,lo}, updated at SEND entry
//   frame_done       : one-cycle pulse once the frame is fully handed off
module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter int unsigned BYTES      = 6,
  parameter int unsigned GAP_CYCLES = 3500
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [8*BYTES-1:0] data_in,
  input  logic               tx_start,
  output logic               busy,
  output logic [7:0]         tx_byte,
  output logic               tx_byte_valid,
  input  logic               tx_byte_ready,
  output logic [15:0]        crc_out,
  output logic               frame_done
);

  localparam int unsigned DATA_W = 8 * BYTES;
  localparam int unsigned CNT_W  = cnt_width(BYTES);

  localparam logic [CNT_W-1:0] LAST_PAY_IDX = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CRC_LO_IDX   = CNT_W'(BYTES);
  localparam logic [CNT_W-1:0] CRC_HI_IDX   = CNT_W'(BYTES + 1);

`ifdef MODBUS_TX_GAP_EN
  localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`endif

  if ((BYTES == 0) || (BYTES > 255) || (GAP_CYCLES == 0)) begin : g_param_check
    $error("modbus_tx_framer: BYTES must be 1..255 and GAP_CYCLES must be >= 1");
  end

  tx_state_t         state;
  logic [DATA_W-1:0] data_hold;   // frame copy kept for the SEND phase
  logic [DATA_W-1:0] data_buf;    // working copy, shifted one byte at a time
  logic [CNT_W-1:0]  byte_cnt;    // bytes absorbed (CRC phase) / bytes sent (SEND)
`ifdef MODBUS_TX_GAP_EN
  logic [GAP_W-1:0]  gap_cnt;
`endif

  logic              crc_start_c;
  logic [15:0]       crc_seed_c;
  logic [15:0]       crc_run;
  logic [15:0]       crc_next_c;
  logic              crc_done_c;
  logic [DATA_W-1:0] data_shift_c;

  // First byte seeds from CRC_INIT; later bytes chain from the engine's running CRC.
  assign crc_start_c  = (state == XOR);
  assign crc_seed_c   = (byte_cnt == '0) ? CRC_INIT : crc_run;
  assign data_shift_c = data_buf >> 8;

  modbus_crc16_byte u_crc (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .start      (crc_start_c),
    .byte_in    (data_buf[7:0]),
    .crc_in     (crc_seed_c),
    .crc_out    (crc_run),
    .crc_next_c (crc_next_c),
    .done_c     (crc_done_c)
  );

  // Frame FSM with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      data_hold     <= '0;
      data_buf      <= '0;
      byte_cnt      <= '0;
      busy          <= 1'b0;
      tx_byte       <= 8'h00;
      tx_byte_valid <= 1'b0;
      crc_out       <= 16'h0000;
      frame_done    <= 1'b0;
`ifdef MODBUS_TX_GAP_EN
      gap_cnt       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          data_hold <= data_in;
          data_buf  <= data_in;
          byte_cnt  <= '0;
          state     <= XOR;
        end

        // The CRC engine absorbs data_buf[7:0] this cycle.
        XOR: begin
          state <= SHIFT;
        end

        SHIFT: begin
          if (crc_done_c) begin
            if (byte_cnt == LAST_PAY_IDX) begin
              crc_out       <= crc_next_c;
              data_buf      <= data_hold;
              tx_byte       <= data_hold[7:0];
              tx_byte_valid <= 1'b1;
              byte_cnt      <= '0;
              state         <= SEND;
            end else begin
              data_buf <= data_shift_c;
              byte_cnt <= byte_cnt + CNT_W'(1);
              state    <= XOR;
            end
          end
        end

        // byte_cnt indexes the byte currently presented on tx_byte.
        SEND: begin
          if (tx_byte_valid && tx_byte_ready) begin
            if (byte_cnt == CRC_HI_IDX) begin
              tx_byte_valid <= 1'b0;
`ifdef MODBUS_TX_GAP_EN
              gap_cnt       <= '0;
              state         <= GAP;
`else
              busy          <= 1'b0;
              frame_done    <= 1'b1;
              state         <= DONE;
`endif
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
              if (byte_cnt == CRC_LO_IDX) begin
                tx_byte <= crc_out[15:8];
              end else if (byte_cnt == LAST_PAY_IDX) begin
                tx_byte <= crc_out[7:0];
              end else begin
                data_buf <= data_shift_c;
                tx_byte  <= data_shift_c[7:0];
              end
            end
          end
        end

`ifdef MODBUS_TX_GAP_EN
        // Inter-frame silence: line idle, still busy.
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_tx_framer.sv
// Self-checking bench for modbus_tx_framer (BYTES=6): table of frames with fixed and
// randomized payloads / ready patterns, checked against a bit-serial CRC model, plus
// hand-written reset-mid-frame and idle-ready sequences.
module tb_modbus_tx_framer;

  localparam int unsigned BYTES = 6;
  localparam int unsigned GAP   = 10;
`ifdef MODBUS_TX_GAP_EN
  localparam int DONE_DLY = 1 + GAP;
`else
  localparam int DONE_DLY = 1;
`endif
  localparam int FIRST_VALID = 1 + 9 * BYTES;

  logic              clk_in;
  logic              rst_n_in;
  logic [8*BYTES-1:0] data_in;
  logic              tx_start;
  logic              busy;
  logic [7:0]        tx_byte;
  logic              tx_byte_valid;
  logic              tx_byte_ready;
  logic [15:0]       crc_out;
  logic              frame_done;

  int checks = 0;
  int errors = 0;

  modbus_tx_framer #(.BYTES(BYTES), .GAP_CYCLES(GAP)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .data_in       (data_in),
    .tx_start      (tx_start),
    .busy          (busy),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready),
    .crc_out       (crc_out),
    .frame_done    (frame_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [47:0] payload;
    int          ready_pct;
    bit          disturb;
    logic [15:0] crc_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC: feed the message LSB-first, one bit at a time.
  function automatic logic [15:0] model_crc(input logic [47:0] p);
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    for (int b = 0; b < 48; b++) begin
      fb = c[0] ^ p[b];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  function automatic logic pick(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic run_frame(input logic [47:0] payload, input int ready_pct,
                           input bit disturb, input logic [15:0] crc_exp);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int t, first_valid_t, last_acc_t, done_t, done_cnt;
    bit prev_valid, prev_ready, finished;
    logic [7:0] prev_byte;
    logic [31:0] got_val;

    for (int i = 0; i < 6; i++) exp_q.push_back(payload[8*i +: 8]);
    exp_q.push_back(crc_exp[7:0]);
    exp_q.push_back(crc_exp[15:8]);

    data_in       = payload;
    tx_start      = 1'b1;
    tx_byte_ready = pick(ready_pct);
    @(posedge clk_in); #1;
    tx_start = 1'b0;
    check("busy_rise", busy, 1);

    t = 0; first_valid_t = -1; last_acc_t = -1; done_t = -1; done_cnt = 0;
    finished   = 0;
    prev_valid = tx_byte_valid;
    prev_ready = tx_byte_ready;
    prev_byte  = tx_byte;
    while (!finished && t < 2000) begin
      @(posedge clk_in); #1;
      t++;
      if (prev_valid && prev_ready) begin
        got_q.push_back(prev_byte);
        last_acc_t = t - 1;
      end else if (prev_valid) begin
        check("stall_valid", tx_byte_valid, 1);
        check("stall_byte", tx_byte, prev_byte);
      end
      if (tx_byte_valid && first_valid_t < 0) first_valid_t = t;
      if (got_q.size() == exp_q.size() && !frame_done) begin
        check("gap_valid", tx_byte_valid, 0);
        check("gap_busy", busy, 1);
      end
      if (frame_done) begin
        done_t = t;
        done_cnt++;
        check("done_busy", busy, 0);
        finished = 1;
      end
      if (disturb) begin
        if (t == 20) begin tx_start = 1'b1; data_in = ~payload; end
        if (t == 21) tx_start = 1'b0;
        if (t == 56) tx_start = 1'b1;
        if (t == 57) tx_start = 1'b0;
      end
      tx_byte_ready = pick(ready_pct);
      prev_valid = tx_byte_valid;
      prev_ready = tx_byte_ready;
      prev_byte  = tx_byte;
    end

    check("done_seen", done_cnt, 1);
    check("first_valid_latency", first_valid_t, FIRST_VALID);
    check("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got_val = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
      check($sformatf("byte%0d", i), got_val, {24'h0, exp_q[i]});
    end
    check("crc_out", crc_out, crc_exp);
    check("done_delay", done_t - last_acc_t, DONE_DLY);

    tx_byte_ready = 1'b1;
    @(posedge clk_in); #1;
    check("done_single_pulse", frame_done, 0);
    repeat (disturb ? 60 : 3) @(posedge clk_in);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", tx_byte_valid, 0);
  endtask

  vec_t vecs[7];
  int   pcts[3] = '{30, 70, 100};
  int   bad_cnt;

  initial begin
    rst_n_in = 1'b0; tx_start = 1'b0; tx_byte_ready = 1'b0; data_in = '0;

    vecs[0] = '{48'h0A00_0000_0301, 100, 1'b0, 16'hCDC5};
    vecs[1] = '{48'h0300_0100_0601,  50, 1'b0, 16'h0B98};
    vecs[2] = '{48'h0A00_0000_0301, 100, 1'b1, 16'hCDC5};
    for (int i = 3; i < 7; i++) begin
      vecs[i].payload   = {16'($urandom), 32'($urandom)};
      vecs[i].ready_pct = pcts[$urandom_range(0, 2)];
      vecs[i].disturb   = 1'b0;
      vecs[i].crc_exp   = model_crc(vecs[i].payload);
    end

    // Reset values.
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_valid", tx_byte_valid, 0);
    check("rst_crc_out", crc_out, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n_in = 1'b1;

    // Ready high while idle must not produce bytes.
    tx_byte_ready = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    check("idle_ready_valid", tx_byte_valid, 0);
    check("idle_ready_busy", busy, 0);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].payload, vecs[i].ready_pct, vecs[i].disturb, vecs[i].crc_exp);

    // Reset while the 4th byte is on the bus.
    data_in = 48'h0300_0100_0601;
    tx_byte_ready = 1'b1;
    tx_start = 1'b1;
    @(posedge clk_in); #1;
    tx_start = 1'b0;
    repeat (FIRST_VALID + 3) @(posedge clk_in);
    #1;
    check("pre_reset_valid", tx_byte_valid, 1);
    check("pre_reset_byte3", tx_byte, 8'h01);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_valid", tx_byte_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_crc_out", crc_out, 0);
    check("midrst_tx_byte", tx_byte, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_in); #1;
      if (tx_byte_valid || busy || frame_done) bad_cnt++;
    end
    check("no_resume_after_reset", bad_cnt, 0);
    run_frame(48'h0300_0100_0601, 60, 1'b0, 16'h0B98);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
